// File: rtl/alu_pkg.sv
// Shared encodings and sizes for the operand-fetch stage and the ALU behind it.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_OR  = 4'b0011,
        OP_NOT = 4'b0100,
        OP_SRA = 4'b1000,
        OP_SLL = 4'b1001,
        OP_SRL = 4'b1010,
        OP_ROL = 4'b1100,
        OP_ROR = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_ZERO = 2'b00,
        IMM_SIGN = 2'b01,
        IMM_HIGH = 2'b10,
        IMM_RSVD = 2'b11
    } imm_mode_e;

    // Reserved mode falls through to zero-extension.
    function automatic logic [WIDTH-1:0] ext_imm(input logic [15:0] imm, input logic [1:0] mode);
        case (mode)
            IMM_SIGN: return {{16{imm[15]}}, imm};
            IMM_HIGH: return {imm, 16'h0000};
            default:  return {16'h0000, imm};
        endcase
    endfunction

endpackage

// File: rtl/regfile.sv
// 2-read 1-write register file; R0 reads zero, same-cycle writes bypass to the read ports.
module regfile
    import alu_pkg::*;
#(
    parameter int RF_DEPTH = DEPTH,
    parameter int RF_WIDTH = WIDTH,
    parameter int RF_AW    = $clog2(RF_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [RF_AW-1:0]    waddr,
    input  logic [RF_WIDTH-1:0] wdata,
    input  logic [RF_AW-1:0]    ra,
    input  logic [RF_AW-1:0]    rb,
    output logic [RF_WIDTH-1:0] rda,
    output logic [RF_WIDTH-1:0] rdb
);

    logic [RF_WIDTH-1:0] mem [RF_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RF_DEPTH; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rda = mem[ra];
        rdb = mem[rb];
        if (we && waddr == ra) rda = wdata;
        if (we && waddr == rb) rdb = wdata;
        if (ra == '0) rda = '0;
        if (rb == '0) rdb = '0;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: register read with bypass, immediate select, hazard scoreboard,
// and a single registered output slot feeding the ALU.
module operand_fetch
    import alu_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [AW-1:0]    In_Rs,
    input  logic [AW-1:0]    In_Rt,
    input  logic [AW-1:0]    In_Rd,
    input  logic [15:0]      In_Imm,
    input  logic [1:0]       In_ImmMode,
    input  logic             In_BSel,
    input  logic [3:0]       In_Op,
    input  logic             In_RegWrite,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_A,
    output logic [WIDTH-1:0] Out_B,
    output logic [3:0]       Out_Op,
    output logic [AW-1:0]    Out_Rd,
    output logic             Out_RegWrite,
    input  logic             Wb_En,
    input  logic [AW-1:0]    Wb_Addr,
    input  logic [WIDTH-1:0] Wb_Data,
    input  logic             Flush
);

    logic [DEPTH-1:0] pending, pending_nxt, wb_mask, eff_pend;
    logic [WIDTH-1:0] rd_a, rd_b;
    logic             hazard, accept;

    regfile u_rf (
        .clk   (Clk),
        .rst_n (Reset_n),
        .we    (Wb_En),
        .waddr (Wb_Addr),
        .wdata (Wb_Data),
        .ra    (In_Rs),
        .rb    (In_Rt),
        .rda   (rd_a),
        .rdb   (rd_b)
    );

    // A writeback retiring this cycle already satisfies the consumer through the bypass.
    always_comb begin
        wb_mask = '0;
        if (Wb_En) wb_mask[Wb_Addr] = 1'b1;
        eff_pend = pending & ~wb_mask;
        hazard   = eff_pend[In_Rs] | (!In_BSel & eff_pend[In_Rt]) | (In_RegWrite & eff_pend[In_Rd]);
    end

    assign In_Ready = !hazard && (!Out_Valid || Out_Ready) && !Flush;
    assign accept   = In_Valid && In_Ready;

    // Set is applied last so it wins over a same-cycle clear.
    always_comb begin
        pending_nxt = pending & ~wb_mask;
        if (Flush && Out_Valid && Out_RegWrite) pending_nxt[Out_Rd] = 1'b0;
        if (accept && In_RegWrite) pending_nxt[In_Rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending      <= '0;
            Out_Valid    <= 1'b0;
            Out_A        <= '0;
            Out_B        <= '0;
            Out_Op       <= '0;
            Out_Rd       <= '0;
            Out_RegWrite <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (Flush)          Out_Valid <= 1'b0;
            else if (accept)    Out_Valid <= 1'b1;
            else if (Out_Ready) Out_Valid <= 1'b0;
            if (accept) begin
                Out_A        <= rd_a;
                Out_B        <= In_BSel ? ext_imm(In_Imm, In_ImmMode) : rd_b;
                Out_Op       <= In_Op;
                Out_Rd       <= In_Rd;
                Out_RegWrite <= In_RegWrite;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized checks of operand_fetch against an architectural model.
module tb_operand_fetch;

    logic        Clk, Reset_n;
    logic        In_Valid, In_Ready, In_BSel, In_RegWrite;
    logic [4:0]  In_Rs, In_Rt, In_Rd;
    logic [15:0] In_Imm;
    logic [1:0]  In_ImmMode;
    logic [3:0]  In_Op;
    logic        Out_Valid, Out_Ready, Out_RegWrite;
    logic [31:0] Out_A, Out_B;
    logic [3:0]  Out_Op;
    logic [4:0]  Out_Rd;
    logic        Wb_En, Flush;
    logic [4:0]  Wb_Addr;
    logic [31:0] Wb_Data;

    int npass = 0, ntotal = 0;

    operand_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Rs(In_Rs), .In_Rt(In_Rt), .In_Rd(In_Rd),
        .In_Imm(In_Imm), .In_ImmMode(In_ImmMode), .In_BSel(In_BSel),
        .In_Op(In_Op), .In_RegWrite(In_RegWrite),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_A(Out_A), .Out_B(Out_B), .Out_Op(Out_Op), .Out_Rd(Out_Rd),
        .Out_RegWrite(Out_RegWrite),
        .Wb_En(Wb_En), .Wb_Addr(Wb_Addr), .Wb_Data(Wb_Data),
        .Flush(Flush)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Architectural model: register contents, outstanding writers, one output slot.
    logic [31:0] mreg [32];
    logic [31:0] mpend;
    logic        mvalid, mrw;
    logic [31:0] ma, mb;
    logic [3:0]  mop;
    logic [4:0]  mrd;

    task automatic m_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        mpend = 0; mvalid = 0; ma = 0; mb = 0; mop = 0; mrd = 0; mrw = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'h0;
        if (Wb_En && Wb_Addr == r) return Wb_Data;
        return mreg[r];
    endfunction

    function automatic logic [31:0] m_imm(input logic [15:0] imm, input logic [1:0] mode);
        logic [31:0] v;
        v = {16'h0, imm};
        if (mode == 2'd1 && imm[15]) v = v - 32'h0001_0000 + 32'h0;
        if (mode == 2'd1 && imm[15]) v = 32'hFFFF_0000 | {16'h0, imm};
        if (mode == 2'd2) v = {16'h0, imm} * 32'h0001_0000;
        return v;
    endfunction

    function automatic logic m_ready();
        logic [31:0] busy;
        busy = mpend;
        if (Wb_En) busy[Wb_Addr] = 1'b0;
        if (Flush) return 1'b0;
        if (mvalid && !Out_Ready) return 1'b0;
        if (busy[In_Rs]) return 1'b0;
        if (!In_BSel && busy[In_Rt]) return 1'b0;
        if (In_RegWrite && busy[In_Rd]) return 1'b0;
        return 1'b1;
    endfunction

    // Advance DUT and model one clock; returns at the following falling edge.
    task automatic tick();
        logic        acc, nv;
        logic [31:0] na, nb, np;
        acc = In_Valid && m_ready();
        na  = m_read(In_Rs);
        nb  = In_BSel ? m_imm(In_Imm, In_ImmMode) : m_read(In_Rt);
        np  = mpend;
        if (Wb_En) np[Wb_Addr] = 1'b0;
        if (Flush && mvalid && mrw && mrd != 0) np[mrd] = 1'b0;
        if (acc && In_RegWrite && In_Rd != 0) np[In_Rd] = 1'b1;
        nv = Flush ? 1'b0 : acc ? 1'b1 : (mvalid && !Out_Ready);
        @(posedge Clk);
        if (Wb_En && Wb_Addr != 0) mreg[Wb_Addr] = Wb_Data;
        mpend = np; mvalid = nv;
        if (acc) begin ma = na; mb = nb; mop = In_Op; mrd = In_Rd; mrw = In_RegWrite; end
        @(negedge Clk);
    endtask

    task automatic idle();
        In_Valid = 0; In_Rs = 0; In_Rt = 0; In_Rd = 0; In_Imm = 0; In_ImmMode = 0;
        In_BSel = 0; In_Op = 0; In_RegWrite = 0; Out_Ready = 1; Wb_En = 0; Wb_Addr = 0;
        Wb_Data = 0; Flush = 0;
    endtask

    task automatic issue(input logic [4:0] rs, rt, rd, input logic bsel, rw,
                         input logic [15:0] imm, input logic [1:0] mode, input logic [3:0] op);
        In_Valid = 1; In_Rs = rs; In_Rt = rt; In_Rd = rd; In_BSel = bsel; In_RegWrite = rw;
        In_Imm = imm; In_ImmMode = mode; In_Op = op;
    endtask

    task automatic test_reset();
        idle();
        Reset_n = 0;
        m_reset();
        repeat (2) @(negedge Clk);
        ntotal++; if (Out_Valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", Out_Valid); else npass++;
        ntotal++; if ({Out_A, Out_B} !== 64'h0) $display("FAIL reset_ab: got %h/%h want 0/0", Out_A, Out_B); else npass++;
        ntotal++; if ({Out_Op, Out_Rd, Out_RegWrite} !== 10'h0) $display("FAIL reset_ctl: got op %h rd %0d rw %b want 0", Out_Op, Out_Rd, Out_RegWrite); else npass++;
        ntotal++; if (dut.pending !== 32'h0) $display("FAIL reset_pending: got %h want 0", dut.pending); else npass++;
        Reset_n = 1;
        tick();
    endtask

    task automatic test_basic();
        Wb_En = 1; Wb_Addr = 5; Wb_Data = 32'h0000_000A;
        tick();
        Wb_En = 0;
        issue(5, 0, 6, 0, 1, 16'h0, 2'd0, 4'b0000);
        #1;
        ntotal++; if (In_Ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", In_Ready); else npass++;
        tick();
        In_Valid = 0;
        ntotal++; if (Out_Valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", Out_Valid); else npass++;
        ntotal++; if (Out_A !== 32'hA || Out_B !== 32'h0) $display("FAIL basic_ab: got %h/%h want 0000000a/00000000", Out_A, Out_B); else npass++;
        ntotal++; if (Out_Op !== 4'b0000 || Out_Rd !== 5'd6 || Out_RegWrite !== 1'b1) $display("FAIL basic_ctl: got op %h rd %0d rw %b want 0/6/1", Out_Op, Out_Rd, Out_RegWrite); else npass++;
        ntotal++; if (dut.pending[6] !== 1'b1) $display("FAIL basic_pending6: got %b want 1", dut.pending[6]); else npass++;
        Wb_En = 1; Wb_Addr = 6; Wb_Data = 32'h66;
        tick();
        Wb_En = 0;
    endtask

    task automatic test_imm();
        logic [31:0] want [3];
        want[0] = 32'h0000_8001; want[1] = 32'hFFFF_8001; want[2] = 32'h8001_0000;
        for (int m = 0; m < 3; m++) begin
            issue(0, 0, 0, 1, 0, 16'h8001, m[1:0], 4'b0010);
            tick();
            ntotal++; if (Out_B !== want[m]) $display("FAIL imm_mode%0d: got %h want %h", m, Out_B, want[m]); else npass++;
        end
        In_Valid = 0;
        tick();
    endtask

    task automatic test_raw();
        issue(0, 0, 3, 1, 1, 16'h0, 2'd0, 4'b0000);
        tick();
        issue(3, 0, 0, 1, 0, 16'h0, 2'd0, 4'b0001);
        for (int i = 0; i < 2; i++) begin
            #1;
            ntotal++; if (In_Ready !== 1'b0) $display("FAIL raw_stall%0d: got %b want 0", i, In_Ready); else npass++;
            tick();
        end
        Wb_En = 1; Wb_Addr = 3; Wb_Data = 32'h1234;
        #1;
        ntotal++; if (In_Ready !== 1'b1) $display("FAIL raw_release: got %b want 1", In_Ready); else npass++;
        tick();
        Wb_En = 0; In_Valid = 0;
        ntotal++; if (Out_Valid !== 1'b1 || Out_A !== 32'h1234) $display("FAIL raw_bypass: got v %b a %h want 1/00001234", Out_Valid, Out_A); else npass++;
        tick();
    endtask

    task automatic test_backpressure();
        Out_Ready = 0;
        issue(5, 0, 0, 1, 0, 16'h11, 2'd0, 4'b0001);
        tick();
        issue(5, 0, 0, 1, 0, 16'h22, 2'd0, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            #1;
            ntotal++; if (In_Ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", i, In_Ready); else npass++;
            tick();
            ntotal++; if (Out_Valid !== 1'b1 || Out_A !== 32'hA || Out_B !== 32'h11 || Out_Op !== 4'b0001) $display("FAIL bp_hold%0d: got v %b a %h b %h op %h want 1/a/11/1", i, Out_Valid, Out_A, Out_B, Out_Op); else npass++;
        end
        Out_Ready = 1;
        #1;
        ntotal++; if (In_Ready !== 1'b1) $display("FAIL bp_release: got %b want 1", In_Ready); else npass++;
        tick();
        In_Valid = 0;
        ntotal++; if (Out_B !== 32'h22 || Out_Op !== 4'b0010) $display("FAIL bp_next: got b %h op %h want 22/2", Out_B, Out_Op); else npass++;
        tick();
    endtask

    task automatic test_r0();
        Wb_En = 1; Wb_Addr = 0; Wb_Data = 32'hFFFF_FFFF;
        tick();
        Wb_En = 0;
        issue(0, 0, 0, 0, 1, 16'h0, 2'd0, 4'b0000);
        #1;
        ntotal++; if (In_Ready !== 1'b1) $display("FAIL r0_ready: got %b want 1", In_Ready); else npass++;
        tick();
        In_Valid = 0;
        ntotal++; if (Out_A !== 32'h0 || Out_B !== 32'h0) $display("FAIL r0_read: got %h/%h want 0/0", Out_A, Out_B); else npass++;
        ntotal++; if (dut.pending !== 32'h0) $display("FAIL r0_pending: got %h want 0", dut.pending); else npass++;
        tick();
    endtask

    task automatic test_flush();
        Out_Ready = 0;
        issue(0, 0, 7, 1, 1, 16'h0, 2'd0, 4'b0000);
        tick();
        In_Valid = 0;
        ntotal++; if (dut.pending[7] !== 1'b1) $display("FAIL flush_set7: got %b want 1", dut.pending[7]); else npass++;
        Flush = 1;
        tick();
        Flush = 0;
        ntotal++; if (Out_Valid !== 1'b0 || dut.pending[7] !== 1'b0) $display("FAIL flush_clear: got v %b p7 %b want 0/0", Out_Valid, dut.pending[7]); else npass++;
        Out_Ready = 1;
        issue(7, 7, 0, 0, 0, 16'h0, 2'd0, 4'b0011);
        #1;
        ntotal++; if (In_Ready !== 1'b1) $display("FAIL flush_noStall: got %b want 1", In_Ready); else npass++;
        tick();
        In_Valid = 0;
        ntotal++; if (Out_Valid !== 1'b1) $display("FAIL flush_reissue: got %b want 1", Out_Valid); else npass++;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            In_Valid    = $urandom_range(0, 3) != 0;
            In_Rs       = 5'($urandom_range(0, 7));
            In_Rt       = 5'($urandom_range(0, 7));
            In_Rd       = 5'($urandom_range(0, 7));
            In_Imm      = 16'($urandom);
            In_ImmMode  = 2'($urandom_range(0, 3));
            In_BSel     = 1'($urandom_range(0, 1));
            In_Op       = 4'($urandom_range(0, 15));
            In_RegWrite = 1'($urandom_range(0, 1));
            Out_Ready   = $urandom_range(0, 3) != 0;
            Wb_En       = $urandom_range(0, 2) == 0;
            Wb_Addr     = 5'($urandom_range(0, 7));
            Wb_Data     = $urandom;
            Flush       = $urandom_range(0, 15) == 0;
            #1;
            ntotal++; if (In_Ready !== m_ready()) $display("FAIL rnd_ready@%0d: got %b want %b", n, In_Ready, m_ready()); else npass++;
            tick();
            ntotal++; if (Out_Valid !== mvalid || dut.pending !== mpend) $display("FAIL rnd_state@%0d: got v %b p %h want %b/%h", n, Out_Valid, dut.pending, mvalid, mpend); else npass++;
            if (mvalid) begin
                ntotal++;
                if ({Out_A, Out_B, Out_Op, Out_Rd, Out_RegWrite} !== {ma, mb, mop, mrd, mrw})
                    $display("FAIL rnd_slot@%0d: got %h %h %h %0d %b want %h %h %h %0d %b", n, Out_A, Out_B, Out_Op, Out_Rd, Out_RegWrite, ma, mb, mop, mrd, mrw);
                else npass++;
            end
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        issue(0, 0, 4, 1, 1, 16'h5, 2'd0, 4'b0000);
        Out_Ready = 0;
        tick();
        idle();
        Reset_n = 0;
        #1;
        m_reset();
        ntotal++; if (Out_Valid !== 1'b0 || dut.pending !== 32'h0) $display("FAIL midreset: got v %b p %h want 0/0", Out_Valid, dut.pending); else npass++;
        @(negedge Clk);
        Reset_n = 1;
        issue(5, 0, 0, 0, 0, 16'h0, 2'd0, 4'b0000);
        tick();
        In_Valid = 0;
        ntotal++; if (Out_Valid !== 1'b1 || Out_A !== 32'h0) $display("FAIL midreset_rf: got v %b a %h want 1/0", Out_Valid, Out_A); else npass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm();
        test_raw();
        test_backpressure();
        test_r0();
        test_flush();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
